// File: rtl/instruction_fetch_stage.sv
// Instruction fetch front end: owns the PC, runs a single-outstanding req/ack
// handshake to instruction memory and presents fetched words from a 2-entry queue.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_4,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  count;
    logic [31:0] head_pc4;
    logic [31:0] head_instr;
    logic [31:0] tail_pc4;
    logic [31:0] tail_instr;

    logic        req_int;
    logic        fire;
    logic        push;
    logic        pop;
    logic [31:0] pc_plus4;

    always_comb begin
        req_int  = (state == S_FETCH) ? (count < 2'd2) : 1'b1;
        // Request is masked while reset is held so memory never sees a stray req.
        imem_req = reset & req_int;
        imem_addr = pc;
        fire     = imem_req & imem_ack;
        push     = fire & (state != S_DROP) & ~redirect;
        pop      = (count != 2'd0) & ~stall & ~redirect;
        pc_plus4 = pc + 32'd4;
    end

    always_comb begin
        if_valid       = (count != 2'd0);
        if_instruction = if_valid ? head_instr : '0;
        if_pc_4        = if_valid ? head_pc4 : 32'd4;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            target <= RESET_PC;
        end else if (redirect) begin
            // An unacked request must still complete, so park the target in DROP.
            if (fire || !req_int) begin
                pc    <= redirect_pc;
                state <= S_FETCH;
            end else begin
                target <= redirect_pc;
                state  <= S_DROP;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (fire) begin
                        pc <= pc_plus4;
                    end else if (req_int) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        pc    <= pc_plus4;
                        state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        pc    <= target;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            head_pc4   <= 32'd4;
            head_instr <= '0;
            tail_pc4   <= 32'd4;
            tail_instr <= '0;
        end else if (redirect) begin
            count <= '0;
        end else begin
            // A push only happens with count <= 1, so the tail never overflows.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc4   <= pc_plus4;
                        head_instr <= imem_rdata;
                    end else begin
                        tail_pc4   <= pc_plus4;
                        tail_instr <= imem_rdata;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc4   <= tail_pc4;
                    head_instr <= tail_instr;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc4   <= pc_plus4;
                        head_instr <= imem_rdata;
                    end else begin
                        head_pc4   <= tail_pc4;
                        head_instr <= tail_instr;
                        tail_pc4   <= pc_plus4;
                        tail_instr <= imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, corner-case sequences
// and randomized traffic checked against a transaction-level queue model.
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;
    logic        if_valid;

    int unsigned checks = 0;
    int unsigned errors = 0;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .if_pc_4(if_pc_4),
        .if_instruction(if_instruction),
        .if_valid(if_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        stall;
        logic        ack;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic ak, input logic v,
                                input logic [31:0] pc4, input logic rq, input logic [31:0] ad);
        vec_t r;
        r.stall = st;
        r.ack   = ak;
        r.valid = v;
        r.instr = v ? mem_word(pc4 - 32'd4) : 32'd0;
        r.pc4   = v ? pc4 : 32'd4;
        r.req   = rq;
        r.addr  = ad;
        return r;
    endfunction

    // Reference model: expected queue contents plus the one outstanding request.
    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_next_pc;
    logic [31:0] m_busy_addr;
    bit          m_busy;
    bit          m_discard;

    function automatic void model_reset();
        mq.delete();
        m_next_pc   = 32'h0;
        m_busy_addr = 32'h0;
        m_busy      = 1'b0;
        m_discard   = 1'b0;
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instruction, 32'd0);
        chk("rst_pc4", if_pc_4, 32'd4);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    // One cycle: starts and ends at a falling edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic ak);
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          fire;
        ent_t        e;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ak;
        #1;
        exp_req  = m_busy || (mq.size() < 2);
        exp_addr = m_busy ? m_busy_addr : m_next_pc;
        chk("valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
        chk("instr", if_instruction, (mq.size() != 0) ? mq[0].instr : 32'd0);
        chk("pc4", if_pc_4, (mq.size() != 0) ? mq[0].pc4 : 32'd4);
        chk("req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("addr", imem_addr, exp_addr);
        fire = exp_req && ak;
        if (rd) begin
            mq.delete();
            if (exp_req && !ak) begin
                m_busy      = 1'b1;
                m_busy_addr = exp_addr;
                m_discard   = 1'b1;
            end else begin
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end
            m_next_pc = rpc;
        end else begin
            if (mq.size() != 0 && !st) void'(mq.pop_front());
            if (fire) begin
                if (!m_discard) begin
                    e.pc4   = exp_addr + 32'd4;
                    e.instr = mem_word(exp_addr);
                    mq.push_back(e);
                    m_next_pc = exp_addr + 32'd4;
                end
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end else if (exp_req) begin
                m_busy      = 1'b1;
                m_busy_addr = exp_addr;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(0, 1, 0, 32'd4,  1, 32'd0);
        tbl[1]  = mk(0, 1, 1, 32'd4,  1, 32'd4);
        tbl[2]  = mk(0, 1, 1, 32'd8,  1, 32'd8);
        tbl[3]  = mk(1, 1, 1, 32'd12, 1, 32'd12);
        tbl[4]  = mk(1, 1, 1, 32'd12, 0, 32'd16);
        tbl[5]  = mk(1, 1, 1, 32'd12, 0, 32'd16);
        tbl[6]  = mk(1, 1, 1, 32'd12, 0, 32'd16);
        tbl[7]  = mk(1, 1, 1, 32'd12, 0, 32'd16);
        tbl[8]  = mk(0, 1, 1, 32'd12, 0, 32'd16);
        tbl[9]  = mk(0, 1, 1, 32'd16, 1, 32'd16);
        tbl[10] = mk(0, 1, 1, 32'd20, 1, 32'd20);
        tbl[11] = mk(0, 1, 1, 32'd24, 1, 32'd24);

        @(negedge clock);
        do_reset();
        foreach (tbl[i]) begin
            stall    = tbl[i].stall;
            redirect = 1'b0;
            imem_ack = tbl[i].ack;
            #1;
            chk($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("tbl%0d_instr", i), if_instruction, tbl[i].instr);
            chk($sformatf("tbl%0d_pc4", i), if_pc_4, tbl[i].pc4);
            chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            @(posedge clock);
            @(negedge clock);
        end

        // Slow memory on 0x8, redirected to 0x100 mid-wait.
        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h100, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Redirect with ack while stalled and full.
        do_reset();
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 32'h200, 1);
        chk("full_redir_addr", imem_addr, 32'h200);
        chk("full_redir_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1);

        // Redirect coinciding with an acked request.
        do_reset();
        step(0, 0, 0, 1);
        step(1, 1, 32'h300, 1);
        chk("ack_redir_addr", imem_addr, 32'h300);
        chk("ack_redir_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1);

        // Reset in the middle of a wait.
        do_reset();
        step(0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, if_valid}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Address wrap.
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        chk("wrap_pc4", if_pc_4, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        step(0, 0, 0, 1);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
